// File: rtl/taillight_pkg.sv
// Shared types and sizing helpers for the sequential tail-light controller.
package taillight_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_TURN_L,
    MODE_TURN_R,
    MODE_HAZ
  } mode_e;

  function automatic int phase_width(input int n_lamps);
    return $clog2(n_lamps + 1);
  endfunction

endpackage

// File: rtl/pwm_dim.sv
// Free-running PWM counter producing the dim enable for the running lights.
module pwm_dim #(
  parameter int PWM_BITS = 4,
  parameter int DIM_DUTY = 4
) (
  input  logic clk,
  input  logic rst,
  output logic dim
);

  localparam int DUTY_W = PWM_BITS + 1;
  localparam logic [DUTY_W-1:0]   DUTY    = DUTY_W'(DIM_DUTY);
  localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);

  logic [PWM_BITS-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_ONE;
    end
  end

  // One extra compare bit lets DIM_DUTY = 2^PWM_BITS mean "always on".
  assign dim = ({1'b0, cnt_reg} < DUTY);

endmodule

// File: rtl/taillight_seq.sv
// Tail-light controller: outward-filling turn sequence, hazard flash,
// brake override and PWM-dimmed running lights for N lamps per side.
module taillight_seq
  import taillight_pkg::*;
#(
  parameter int N_LAMPS  = 3,
  parameter int STEP_DIV = 4,
  parameter int PWM_BITS = 4,
  parameter int DIM_DUTY = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               left,
  input  logic               right,
  input  logic               brake,
  input  logic               hazard,
  input  logic               runlight,
  output logic [N_LAMPS-1:0] lights_l,
  output logic [N_LAMPS-1:0] lights_r
);

  localparam int PH_W  = phase_width(N_LAMPS);
  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PRE_W-1:0]   PRE_ONE  = PRE_W'(1);
  localparam logic [PH_W-1:0]    PH_LAST  = PH_W'(N_LAMPS);
  localparam logic [PH_W-1:0]    PH_ONE   = PH_W'(1);
  localparam logic [N_LAMPS-1:0] ALL_ON   = '1;

  if (N_LAMPS < 1) begin : g_bad_lamps
    $error("taillight_seq: N_LAMPS must be at least 1");
  end
  if (STEP_DIV < 1) begin : g_bad_div
    $error("taillight_seq: STEP_DIV must be at least 1");
  end
  if (DIM_DUTY > (2 ** PWM_BITS)) begin : g_bad_duty
    $error("taillight_seq: DIM_DUTY exceeds 2^PWM_BITS");
  end

  mode_e               mode_reg;
  mode_e               mode_next;
  logic [PH_W-1:0]     ph_reg;
  logic [PRE_W-1:0]    pre_reg;
  logic                tick;
  logic                dim;
  logic [N_LAMPS-1:0]  turn_pat;
  logic [N_LAMPS-1:0]  lit_l;
  logic [N_LAMPS-1:0]  lit_r;
  logic [N_LAMPS-1:0]  lights_l_next;
  logic [N_LAMPS-1:0]  lights_r_next;

  pwm_dim #(
    .PWM_BITS (PWM_BITS),
    .DIM_DUTY (DIM_DUTY)
  ) u_pwm_dim (
    .clk (clk),
    .rst (rst),
    .dim (dim)
  );

  always_comb begin
    mode_next = MODE_IDLE;
    if (hazard || (left && right)) begin
      mode_next = MODE_HAZ;
    end else if (left) begin
      mode_next = MODE_TURN_L;
    end else if (right) begin
      mode_next = MODE_TURN_R;
    end
  end

  assign tick = (pre_reg == PRE_LAST);

  // A mode change always wins over a coincident tick and restarts at ph=1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_reg <= MODE_IDLE;
      pre_reg  <= '0;
      ph_reg   <= '0;
    end else if (mode_next != mode_reg) begin
      mode_reg <= mode_next;
      pre_reg  <= '0;
      ph_reg   <= PH_ONE;
    end else begin
      pre_reg <= tick ? '0 : (pre_reg + PRE_ONE);
      case (mode_reg)
        MODE_TURN_L, MODE_TURN_R: begin
          if (tick) begin
            ph_reg <= (ph_reg == PH_LAST) ? '0 : (ph_reg + PH_ONE);
          end
        end
        MODE_HAZ: begin
          if (tick) begin
            ph_reg <= (ph_reg == PH_ONE) ? '0 : PH_ONE;
          end
        end
        default: ph_reg <= '0;
      endcase
    end
  end

  for (genvar gi = 0; gi < N_LAMPS; gi++) begin : g_turn_pat
    assign turn_pat[gi] = (ph_reg > PH_W'(gi));
  end

  always_comb begin
    lit_l = '0;
    lit_r = '0;
    case (mode_reg)
      MODE_TURN_L: begin
        lit_l = turn_pat;
        lit_r = brake ? ALL_ON : '0;
      end
      MODE_TURN_R: begin
        lit_l = brake ? ALL_ON : '0;
        lit_r = turn_pat;
      end
      MODE_HAZ: begin
        lit_l = (ph_reg == PH_ONE) ? ALL_ON : '0;
        lit_r = (ph_reg == PH_ONE) ? ALL_ON : '0;
      end
      default: begin
        lit_l = brake ? ALL_ON : '0;
        lit_r = brake ? ALL_ON : '0;
      end
    endcase
    // Unlit lamps take the dim level; lit lamps are already fully on.
    lights_l_next = lit_l | {N_LAMPS{runlight & dim}};
    lights_r_next = lit_r | {N_LAMPS{runlight & dim}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lights_l <= '0;
      lights_r <= '0;
    end else begin
      lights_l <= lights_l_next;
      lights_r <= lights_r_next;
    end
  end

endmodule

// File: doc/taillight_seq.md
# taillight_seq

Parametrised sequential tail-light controller: drives N lamps per side with outward-filling turn sequence, hazard flash, brake override and PWM-dimmed running lights. Successor to the fixed 3+3 lamp controller. It replaces the separate state-machine and running-light stages with one block clocked from the system clock; the step rate and dim level are derived internally.

## Interface
- N_LAMPS, 3, lamps per side (≥1); index 0 innermost
- STEP_DIV, 4, clk cycles per sequence step (≥1)
- PWM_BITS, 4, width of dim PWM counter
- DIM_DUTY, 4, PWM on-count for running light (0..2^PWM_BITS)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- left  in  1  left turn request
- right  in  1  right turn request
- brake  in  1  brake pedal
- hazard  in  1  hazard switch
- runlight  in  1  running lights enable
- lights_l  out  N_LAMPS  left lamp drive, registered
- lights_r  out  N_LAMPS  right lamp drive, registered

## Operation
- Mode decode from inputs, sampled every clk: hazard or (left and right) → HAZ; else left → TURN_L; else right → TURN_R; else IDLE.
- Mode register `mode`; when the decoded mode ≠ `mode`, load the new mode, clear the prescaler to 0, and set phase `ph`=1.
- Prescaler counts 0..STEP_DIV-1 and wraps. A tick occurs on the cycle it equals STEP_DIV-1.
- TURN: on tick, `ph` advances 0→1→…→N_LAMPS→0. The turning side lights lamp i iff i < `ph`, so a cycle is N_LAMPS+1 steps and includes one all-off step.
- HAZ: `ph` toggles between 1 and 0 on tick. Both sides are all-on when `ph`=1 and all-off when `ph`=0.
- IDLE: `ph` is held at 0.
- Brake:
  - IDLE: both sides all-on.
  - TURN: the non-turning side is all-on; the turning side keeps its sequence.
  - HAZ: ignored.
- Runlight: a free-running PWM counter, PWM_BITS wide, wraps at 2^PWM_BITS-1. Dim = (pwm_cnt < DIM_DUTY). While runlight=1, every lamp not lit by the rules above is driven with dim. DIM_DUTY=0 means dim is never on; DIM_DUTY=2^PWM_BITS means dim is always on.
- Lamp outputs are registered from the combinational pattern of `mode`, `ph`, brake, runlight and dim.

## Timing
- Reset (rst=0, asynchronous): lights_l=lights_r=0, mode=IDLE, ph=0, prescaler=0, pwm_cnt=0. Release is synchronous to the next edge.
- Latency:
  - An input change before edge k is loaded into `mode` at edge k.
  - Lights reflect it at edge k+1.
  - brake and runlight are not stored in state, so they appear at the lights one edge after sampling.
- First TURN step: lamp 0 lights one edge after the mode load and stays lit for STEP_DIV cycles. Lamp 1 is added at the first tick.
- Step duration: exactly STEP_DIV cycles per `ph` value, including the first step after a mode change.
- A mode change mid-sequence (e.g. left→right, or hazard asserted during a turn) restarts at `ph`=1 immediately. Partial sequences are not completed.
- Input glitches shorter than a cycle are not filtered; a one-cycle pulse on left restarts the sequence.
- If a tick and a mode change coincide, the mode change wins: `ph`=1 and the prescaler is 0.
- The PWM counter runs independently of mode changes and is cleared only by reset.
- STEP_DIV=1: `ph` advances every cycle.
- N_LAMPS=1: TURN alternates on/off like HAZ on one side.

## Structure
- Package taillight_pkg:
  - mode_e enum {MODE_IDLE, MODE_TURN_L, MODE_TURN_R, MODE_HAZ}.
  - Function for the phase width: $clog2(N_LAMPS+1).
- Sub-module pwm_dim: PWM_BITS counter plus compare. Parameters PWM_BITS and DIM_DUTY; ports clk, rst, dim out.
- The prescaler, phase FSM and output mux stay in taillight_seq.
- Elaboration assertions: N_LAMPS≥1, STEP_DIV≥1, DIM_DUTY≤2^PWM_BITS.

## Test plan
All scenarios use the defaults: N_LAMPS=3, STEP_DIV=4, PWM_BITS=4, DIM_DUTY=4.
- **Reset:** hold rst=0 with all inputs high. Required: lights 000/000. Release with inputs low → lights stay 000/000.
- **Left turn:** raise left at edge k. Required:
  - lights_l=001 from edge k+1, 011 at k+5, 111 at k+9, 000 at k+13, 001 at k+17.
  - lights_r=000 throughout.
- **Brake during right turn:** right turn with brake=1. Required: lights_l=111 steady; lights_r sequences 001/011/111/000. Drop right with brake held → both sides 111 two edges later.
- **Hazard priority:** hazard=1 mid left-turn (lights_l=011). Required: both sides 111 one edge after the mode load, then 000 four cycles later, toggling every 4 cycles. Brake has no effect. Left+right together behaves identically.
- **Running light:** runlight=1, IDLE. Required: every lamp high for 4 of each 16 cycles, in phase. During a left turn at lights_l pattern 001, lamps 1–2 dim while lamp 0 is solid.
- **Restart on glitch:** a one-cycle left pulse during a right turn, then right again. Required: the right sequence restarts at 001, with lights_l showing a 001 step in between.
